// File: rtl/security_zone_controller.sv
// Multi-zone intrusion controller: arm/disarm modes, exit/entry delays,
// user passcode with change sequence, and wrong-code lockout.
module security_zone_controller #(
  parameter int NUM_ZONES     = 4,
  parameter int CODE_W        = 4,
  parameter int EXIT_DLY_CYC  = 100000000,
  parameter int ENTRY_DLY_CYC = 500000000,
  parameter int MAX_ATTEMPTS  = 3,
  parameter int LOCKOUT_CYC   = 250000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_mode_n,
  input  logic                 btn_enter_n,
  input  logic [CODE_W-1:0]    code_in,
  input  logic [NUM_ZONES-1:0] zone_trip,
  input  logic [NUM_ZONES-1:0] stay_mask,
  output logic [1:0]           mode,
  output logic [1:0]           alarm_state,
  output logic [NUM_ZONES-1:0] tripped_zones,
  output logic                 code_ok,
  output logic                 code_bad,
  output logic                 locked_out,
  output logic [2:0]           display_sel
);

  typedef enum logic [1:0] {MODE_UNARM, MODE_ARMS, MODE_ARMA, MODE_RESET} mode_e;
  typedef enum logic [1:0] {AL_OFF, AL_ON, AL_AWAYSEQ, AL_POLICE} alarm_e;

  localparam int EXIT_W  = $clog2(EXIT_DLY_CYC + 1);
  localparam int ENTRY_W = $clog2(ENTRY_DLY_CYC + 1);
  localparam int LOCK_W  = $clog2(LOCKOUT_CYC + 1);
  localparam int ATT_W   = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [EXIT_W-1:0]  EXIT_LAST  = EXIT_W'(EXIT_DLY_CYC - 1);
  localparam logic [ENTRY_W-1:0] ENTRY_LAST = ENTRY_W'(ENTRY_DLY_CYC - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [ATT_W-1:0]   ATT_MAX    = ATT_W'(MAX_ATTEMPTS);

  // Two synchroniser stages plus one history stage per button.
  logic [2:0] mode_sync, enter_sync;
  logic       mode_ev, enter_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sync  <= '1;
      enter_sync <= '1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      mode_sync  <= {mode_sync[1:0], btn_mode_n};
      enter_sync <= {enter_sync[1:0], btn_enter_n};
    end
  end

  assign mode_ev  = mode_sync[2]  & ~mode_sync[1];
  assign enter_ev = enter_sync[2] & ~enter_sync[1];

  mode_e                mode_q, mode_d, mode_next;
  alarm_e               alarm_q, alarm_d;
  logic [NUM_ZONES-1:0] tripped_q, tripped_d, armed, hits;
  logic [CODE_W-1:0]    stored_q, stored_d;
  logic [EXIT_W-1:0]    exit_cnt_q, exit_cnt_d;
  logic [ENTRY_W-1:0]   entry_cnt_q, entry_cnt_d;
  logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [ATT_W-1:0]     attempts_q, attempts_d;
  logic                 locked_q, locked_d;
  logic                 confirm_q, confirm_d;
  logic                 ok_q, ok_d, bad_q, bad_d;
  logic [2:0]           disp_q, disp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_UNARM;
      alarm_q     <= AL_OFF;
      tripped_q   <= '0;
      stored_q    <= '0;
      exit_cnt_q  <= '0;
      entry_cnt_q <= '0;
      lock_cnt_q  <= '0;
      attempts_q  <= '0;
      locked_q    <= 1'b0;
      confirm_q   <= 1'b0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      disp_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      alarm_q     <= alarm_d;
      tripped_q   <= tripped_d;
      stored_q    <= stored_d;
      exit_cnt_q  <= exit_cnt_d;
      entry_cnt_q <= entry_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      attempts_q  <= attempts_d;
      locked_q    <= locked_d;
      confirm_q   <= confirm_d;
      ok_q        <= ok_d;
      bad_q       <= bad_d;
      disp_q      <= disp_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    mode_d      = mode_q;
    alarm_d     = alarm_q;
    tripped_d   = tripped_q;
    stored_d    = stored_q;
    exit_cnt_d  = exit_cnt_q;
    entry_cnt_d = entry_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    attempts_d  = attempts_q;
    locked_d    = locked_q;
    confirm_d   = confirm_q;
    ok_d        = 1'b0;
    bad_d       = 1'b0;
    disp_d      = disp_q;
    mode_next   = mode_e'(mode_q + 2'd1);

    unique case (mode_q)
      MODE_ARMS: armed = stay_mask;
      MODE_ARMA: armed = '1;
      default:   armed = '0;
    endcase
    hits = zone_trip & armed;

    unique case (alarm_q)
      AL_AWAYSEQ: begin
        if (exit_cnt_q == EXIT_LAST) begin
          alarm_d    = AL_OFF;
          exit_cnt_d = '0;
        end else begin
          exit_cnt_d = exit_cnt_q + EXIT_W'(1);
        end
      end
      AL_OFF: begin
        if (hits != '0) begin
          alarm_d     = AL_ON;
          tripped_d   = tripped_q | hits;
          entry_cnt_d = '0;
        end
      end
      AL_ON: begin
        tripped_d = tripped_q | hits;
        if (entry_cnt_q == ENTRY_LAST) begin
          alarm_d     = AL_POLICE;
          entry_cnt_d = '0;
        end else begin
          entry_cnt_d = entry_cnt_q + ENTRY_W'(1);
        end
      end
      default: ;
    endcase

    if (locked_q) begin
      if (lock_cnt_q == LOCK_LAST) begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
        attempts_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
    end

    // A mode event always swallows a same-cycle enter event, even when ignored.
    if (mode_ev) begin
      if (alarm_q != AL_ON && alarm_q != AL_POLICE) begin
        mode_d      = mode_next;
        alarm_d     = (mode_next == MODE_ARMA) ? AL_AWAYSEQ : AL_OFF;
        tripped_d   = '0;
        exit_cnt_d  = '0;
        entry_cnt_d = '0;
        lock_cnt_d  = '0;
        attempts_d  = '0;
        locked_d    = 1'b0;
        confirm_d   = 1'b0;
        disp_d      = {1'b0, mode_next};
      end
    end else if (enter_ev && !locked_q && mode_q != MODE_UNARM) begin
      if (mode_q == MODE_RESET && confirm_q) begin
        stored_d  = code_in;
        disp_d    = 3'd4;
        confirm_d = 1'b0;
      end else if (code_in == stored_q) begin
        ok_d       = 1'b1;
        attempts_d = '0;
        if (mode_q == MODE_RESET) begin
          confirm_d = 1'b1;
        end else begin
          alarm_d     = AL_OFF;
          tripped_d   = tripped_q;
          exit_cnt_d  = '0;
          entry_cnt_d = '0;
        end
      end else begin
        bad_d      = 1'b1;
        attempts_d = attempts_q + ATT_W'(1);
        if (attempts_d == ATT_MAX) begin
          locked_d   = 1'b1;
          lock_cnt_d = '0;
          if (alarm_q == AL_ON) begin
            alarm_d     = AL_POLICE;
            entry_cnt_d = '0;
          end
        end
      end
    end
  end

  assign mode          = mode_q;
  assign alarm_state   = alarm_q;
  assign tripped_zones = tripped_q;
  assign code_ok       = ok_q;
  assign code_bad      = bad_q;
  assign locked_out    = locked_q;
  assign display_sel   = disp_q;

endmodule

// File: tb/tb_security_zone_controller.sv
// Directed bench for security_zone_controller with short delay parameters.
module tb_security_zone_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode_n = 1'b1, btn_enter_n = 1'b1;
  logic [3:0] code_in = '0, zone_trip = '0, stay_mask = '0;
  logic [1:0] mode, alarm_state;
  logic [3:0] tripped_zones;
  logic       code_ok, code_bad, locked_out;
  logic [2:0] display_sel;

  int tests_run = 0;
  int tests_failed = 0;

  security_zone_controller #(
    .NUM_ZONES(4), .CODE_W(4), .EXIT_DLY_CYC(8), .ENTRY_DLY_CYC(20),
    .MAX_ATTEMPTS(3), .LOCKOUT_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode_n(btn_mode_n), .btn_enter_n(btn_enter_n),
    .code_in(code_in), .zone_trip(zone_trip), .stay_mask(stay_mask),
    .mode(mode), .alarm_state(alarm_state), .tripped_zones(tripped_zones),
    .code_ok(code_ok), .code_bad(code_bad), .locked_out(locked_out),
    .display_sel(display_sel)
  );

  always #5 clk = ~clk;

  task automatic reset_dut();
    rst = 1'b1; btn_mode_n = 1'b1; btn_enter_n = 1'b1;
    code_in = '0; zone_trip = '0; stay_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Press lands in the registers on the 3rd edge; pulses are sampled there.
  task automatic press(input bit is_mode, input logic [3:0] code,
                       output logic ok, output logic bad);
    @(negedge clk);
    code_in = code;
    if (is_mode) btn_mode_n = 1'b0; else btn_enter_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ok = code_ok; bad = code_bad;
    btn_mode_n = 1'b1; btn_enter_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b1;
    #2;
    obs = {mode, alarm_state, tripped_zones, code_ok, code_bad, locked_out, display_sel};
    tests_run++;
    if (obs !== 16'h0) begin tests_failed++; $display("FAIL reset_state: got %h want 0000", obs); end
    reset_dut();
    @(posedge clk); #1;
    obs = {mode, alarm_state, tripped_zones, code_ok, code_bad, locked_out, display_sel};
    tests_run++;
    if (obs !== 16'h0) begin tests_failed++; $display("FAIL post_reset_idle: got %h want 0000", obs); end
  endtask

  task automatic test_stay_police();
    logic ok, bad;
    reset_dut();
    @(negedge clk); btn_mode_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if (mode !== 2'b00) begin tests_failed++; $display("FAIL mode_latency_early: got %b want 00", mode); end
    @(posedge clk); #1;
    tests_run++;
    if (mode !== 2'b01 || display_sel !== 3'd1) begin
      tests_failed++; $display("FAIL mode_arms: got mode %b disp %0d want 01/1", mode, display_sel);
    end
    btn_mode_n = 1'b1;
    repeat (3) @(posedge clk);
    stay_mask = 4'b0011; zone_trip = 4'b0100;
    repeat (5) @(posedge clk); #1;
    tests_run++;
    if (alarm_state !== 2'b00) begin tests_failed++; $display("FAIL unarmed_zone: got %b want 00", alarm_state); end
    @(negedge clk); zone_trip = 4'b0001;
    @(posedge clk); #1;
    zone_trip = 4'b0000;
    tests_run++;
    if (alarm_state !== 2'b01 || tripped_zones !== 4'b0001) begin
      tests_failed++; $display("FAIL stay_trip: got alarm %b zones %b want 01/0001", alarm_state, tripped_zones);
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (alarm_state !== ((i < 20) ? 2'b01 : 2'b11)) begin
        tests_failed++; $display("FAIL entry_delay clk %0d: got %b want %b", i, alarm_state, (i < 20) ? 2'b01 : 2'b11);
      end
    end
    press(1'b1, 4'h0, ok, bad);
    tests_run++;
    if (mode !== 2'b01 || alarm_state !== 2'b11 || tripped_zones !== 4'b0001) begin
      tests_failed++; $display("FAIL mode_in_police: got mode %b alarm %b zones %b want 01/11/0001", mode, alarm_state, tripped_zones);
    end
  endtask

  task automatic test_code_clear();
    logic ok, bad;
    reset_dut();
    press(1'b1, 4'h0, ok, bad);
    stay_mask = 4'b0011;
    @(negedge clk); zone_trip = 4'b0001;
    @(posedge clk); #1;
    zone_trip = 4'b0000;
    repeat (2) @(posedge clk);
    press(1'b0, 4'b0000, ok, bad);
    tests_run++;
    if (ok !== 1'b1 || bad !== 1'b0) begin tests_failed++; $display("FAIL good_code_pulse: got ok %b bad %b want 1/0", ok, bad); end
    tests_run++;
    if (alarm_state !== 2'b00 || mode !== 2'b01 || tripped_zones !== 4'b0001) begin
      tests_failed++; $display("FAIL disarm_alarm: got alarm %b mode %b zones %b want 00/01/0001", alarm_state, mode, tripped_zones);
    end
    tests_run++;
    if (code_ok !== 1'b0) begin tests_failed++; $display("FAIL ok_pulse_width: got %b want 0", code_ok); end
  endtask

  task automatic test_lockout();
    logic ok, bad;
    reset_dut();
    press(1'b1, 4'h0, ok, bad);
    stay_mask = 4'b0011;
    @(negedge clk); zone_trip = 4'b0001;
    @(posedge clk); #1;
    zone_trip = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      press(1'b0, 4'b1111, ok, bad);
      tests_run++;
      if (ok !== 1'b0 || bad !== 1'b1) begin tests_failed++; $display("FAIL bad_code_%0d: got ok %b bad %b want 0/1", i, ok, bad); end
      tests_run++;
      if (alarm_state !== ((i < 3) ? 2'b01 : 2'b11) || locked_out !== (i == 3)) begin
        tests_failed++; $display("FAIL lock_state_%0d: got alarm %b lock %b", i, alarm_state, locked_out);
      end
    end
    press(1'b0, 4'b0000, ok, bad);
    tests_run++;
    if (ok !== 1'b0 || bad !== 1'b0 || locked_out !== 1'b1) begin
      tests_failed++; $display("FAIL locked_enter: got ok %b bad %b lock %b want 0/0/1", ok, bad, locked_out);
    end
    @(posedge clk); #1;
    tests_run++;
    if (locked_out !== 1'b0 || alarm_state !== 2'b11) begin
      tests_failed++; $display("FAIL lock_release: got lock %b alarm %b want 0/11", locked_out, alarm_state);
    end
    press(1'b0, 4'b0000, ok, bad);
    tests_run++;
    if (ok !== 1'b1 || alarm_state !== 2'b00 || tripped_zones !== 4'b0001) begin
      tests_failed++; $display("FAIL police_clear: got ok %b alarm %b zones %b want 1/00/0001", ok, alarm_state, tripped_zones);
    end
  endtask

  task automatic test_arma();
    logic ok, bad;
    reset_dut();
    press(1'b1, 4'h0, ok, bad);
    @(negedge clk); btn_mode_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    btn_mode_n = 1'b1;
    tests_run++;
    if (mode !== 2'b10 || alarm_state !== 2'b10 || display_sel !== 3'd2) begin
      tests_failed++; $display("FAIL enter_arma: got mode %b alarm %b disp %0d want 10/10/2", mode, alarm_state, display_sel);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 2) zone_trip = 4'b1000;
      tests_run++;
      if (alarm_state !== ((i < 8) ? 2'b10 : 2'b00) || tripped_zones !== 4'b0000) begin
        tests_failed++; $display("FAIL exit_delay clk %0d: got alarm %b zones %b", i, alarm_state, tripped_zones);
      end
    end
    @(posedge clk); #1;
    zone_trip = 4'b0000;
    tests_run++;
    if (alarm_state !== 2'b01 || tripped_zones !== 4'b1000) begin
      tests_failed++; $display("FAIL away_trip: got alarm %b zones %b want 01/1000", alarm_state, tripped_zones);
    end
  endtask

  task automatic test_code_change();
    logic ok, bad;
    reset_dut();
    for (int i = 0; i < 3; i++) press(1'b1, 4'h0, ok, bad);
    tests_run++;
    if (mode !== 2'b11 || display_sel !== 3'd3 || alarm_state !== 2'b00) begin
      tests_failed++; $display("FAIL reset_mode: got mode %b disp %0d alarm %b want 11/3/00", mode, display_sel, alarm_state);
    end
    press(1'b0, 4'b0000, ok, bad);
    tests_run++;
    if (ok !== 1'b1 || bad !== 1'b0) begin tests_failed++; $display("FAIL confirm_old: got ok %b bad %b want 1/0", ok, bad); end
    press(1'b0, 4'b1010, ok, bad);
    tests_run++;
    if (ok !== 1'b0 || bad !== 1'b0 || display_sel !== 3'd4) begin
      tests_failed++; $display("FAIL store_new: got ok %b bad %b disp %0d want 0/0/4", ok, bad, display_sel);
    end
    press(1'b0, 4'b0000, ok, bad);
    tests_run++;
    if (ok !== 1'b0 || bad !== 1'b1) begin tests_failed++; $display("FAIL old_rejected: got ok %b bad %b want 0/1", ok, bad); end
    press(1'b0, 4'b1010, ok, bad);
    tests_run++;
    if (ok !== 1'b1 || bad !== 1'b0) begin tests_failed++; $display("FAIL new_accepted: got ok %b bad %b want 1/0", ok, bad); end
    press(1'b1, 4'h0, ok, bad);
    tests_run++;
    if (mode !== 2'b00 || display_sel !== 3'd0) begin
      tests_failed++; $display("FAIL mode_wrap: got mode %b disp %0d want 00/0", mode, display_sel);
    end
    press(1'b0, 4'b1010, ok, bad);
    tests_run++;
    if (ok !== 1'b0 || bad !== 1'b0) begin tests_failed++; $display("FAIL unarm_enter: got ok %b bad %b want 0/0", ok, bad); end
    reset_dut();
    for (int i = 0; i < 3; i++) press(1'b1, 4'h0, ok, bad);
    press(1'b0, 4'b0000, ok, bad);
    tests_run++;
    if (ok !== 1'b1 || bad !== 1'b0) begin tests_failed++; $display("FAIL code_after_rst: got ok %b bad %b want 1/0", ok, bad); end
  endtask

  initial begin
    test_reset();
    test_stay_police();
    test_code_clear();
    test_lockout();
    test_arma();
    test_code_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
